// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register command sequencer.
// Mode encodings double as command opcodes, so a command maps directly onto usr_control.
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/usr_len_counter.sv
// Loadable down-counter tracking shifts still to be issued.
// last flags the final shift so the sequencer can leave SHIFT on that edge.
module usr_len_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic             dec,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= len;
    end else if (clr) begin
      count <= '0;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer owning all mode timing of a universal shift register.
// Every output is a register loaded from the next-state logic.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  output logic [1:0]       usr_control,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] shift_rem
);

  state_t     state, state_n;
  logic [1:0] control_n;
  logic       ready_n, busy_n, done_n, aborted_n;
  logic       cnt_load, cnt_clr, cnt_dec, cnt_last;

  usr_len_counter #(.CNT_W(CNT_W)) u_len_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .clr   (cnt_clr),
    .dec   (cnt_dec),
    .len   (cmd_len),
    .count (shift_rem),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      usr_control <= USR_HOLD;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_n;
      usr_control <= control_n;
      cmd_ready   <= ready_n;
      busy        <= busy_n;
      done        <= done_n;
      aborted     <= aborted_n;
    end
  end

  // Shift direction is held in usr_control itself for the whole SHIFT phase.
  always_comb begin
    state_n   = state;
    control_n = usr_control;
    ready_n   = cmd_ready;
    busy_n    = busy;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    cnt_load  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          busy_n  = 1'b1;
          ready_n = 1'b0;
          if (cmd_op == USR_LOAD) begin
            state_n   = LOAD;
            control_n = USR_LOAD;
          end else if ((cmd_op != USR_HOLD) && (cmd_len != '0)) begin
            state_n   = SHIFT;
            control_n = cmd_op;
            cnt_load  = 1'b1;
          end else begin
            state_n   = DONE;
            control_n = USR_HOLD;
            done_n    = 1'b1;
          end
        end
      end
      LOAD: begin
        state_n   = DONE;
        control_n = USR_HOLD;
        done_n    = 1'b1;
      end
      SHIFT: begin
        if (abort) begin
          state_n   = DONE;
          control_n = USR_HOLD;
          done_n    = 1'b1;
          aborted_n = 1'b1;
          cnt_clr   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_n   = DONE;
            control_n = USR_HOLD;
            done_n    = 1'b1;
          end
        end
      end
      DONE: begin
        state_n   = IDLE;
        control_n = USR_HOLD;
        ready_n   = 1'b1;
        busy_n    = 1'b0;
      end
      default: begin
        state_n   = IDLE;
        control_n = USR_HOLD;
        ready_n   = 1'b1;
        busy_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl driving a 4-bit universal shift register, checked every
// cycle against a schedule-queue model plus hand-computed directed expectations.
module tb_usr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       abort = 1'b0;
  logic [1:0] usr_control;
  logic       busy, done, aborted;
  logic [3:0] shift_rem;

  logic [3:0] p_in = 4'd0;
  logic       sr_in = 1'b0;
  logic       sl_in = 1'b0;
  logic [3:0] usr_q = 4'd0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usr_seq_ctrl #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .abort       (abort),
    .usr_control (usr_control),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .shift_rem   (shift_rem)
  );

  // The shift register datapath under control of the sequencer.
  always @(posedge clk) begin
    case (usr_control)
      2'b01:   usr_q <= {sr_in, usr_q[3:1]};
      2'b10:   usr_q <= {usr_q[2:0], sl_in};
      2'b11:   usr_q <= p_in;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted command expands into a list of per-cycle output tuples.
  typedef struct packed {
    logic [1:0] ctrl;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       ready;
    logic [3:0] rem;
  } exp_t;

  function automatic exp_t mk(input logic [1:0] c, input logic b, input logic d,
                              input logic a, input logic r, input logic [3:0] n);
    mk = '{ctrl: c, busy: b, done: d, aborted: a, ready: r, rem: n};
  endfunction

  exp_t       idle_e = '{ctrl: 2'b00, busy: 1'b0, done: 1'b0, aborted: 1'b0, ready: 1'b1, rem: 4'd0};
  exp_t       cur = '{ctrl: 2'b00, busy: 1'b0, done: 1'b0, aborted: 1'b0, ready: 1'b1, rem: 4'd0};
  exp_t       sched[$];
  logic [3:0] q_exp = 4'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      cur = idle_e;
    end else begin
      if (cur.ctrl == 2'b01) q_exp = {sr_in, q_exp[3:1]};
      else if (cur.ctrl == 2'b10) q_exp = {q_exp[2:0], sl_in};
      else if (cur.ctrl == 2'b11) q_exp = p_in;
      if (cur.ready && cmd_valid) begin
        if (cmd_op == 2'b11) begin
          sched.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        end else if (cmd_op != 2'b00) begin
          for (int i = 0; i < int'(cmd_len); i++)
            sched.push_back(mk(cmd_op, 1'b1, 1'b0, 1'b0, 1'b0, 4'(int'(cmd_len) - i)));
        end
        sched.push_back(mk(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
      end else if (abort && (cur.ctrl == 2'b01 || cur.ctrl == 2'b10)) begin
        sched.delete();
        sched.push_back(mk(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0));
      end
      cur = (sched.size() > 0) ? sched.pop_front() : idle_e;
    end
  end

  always @(negedge clk) begin
    check("model_ctrl",    32'(usr_control), 32'(cur.ctrl));
    check("model_busy",    32'(busy),        32'(cur.busy));
    check("model_done",    32'(done),        32'(cur.done));
    check("model_aborted", 32'(aborted),     32'(cur.aborted));
    check("model_ready",   32'(cmd_ready),   32'(cur.ready));
    check("model_rem",     32'(shift_rem),   32'(cur.rem));
    check("model_usr",     32'(usr_q),       32'(q_exp));
  end

  // Returns mid-cycle 1 (just after the accept edge), with op/len scrambled.
  task automatic issue(input logic [1:0] op, input logic [3:0] len);
    int unsigned waited = 0;
    @(posedge clk); #2;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    while (!cmd_ready && waited < 50) begin
      @(posedge clk); #2;
      waited++;
    end
    if (waited >= 50) check("accept_timeout", 32'(waited), 32'd0);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = 4'($urandom);
  endtask

  initial begin
    #12 rst = 1'b0;

    // 1: reset state
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_ctrl",  32'(usr_control), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_rem",   32'(shift_rem), 32'd0);

    // 2: LOAD 1011
    p_in = 4'b1011;
    issue(2'b11, 4'd9);
    @(negedge clk);
    check("load_c1_ctrl", 32'(usr_control), 32'h3);
    check("load_c1_done", 32'(done), 32'd0);
    @(negedge clk);
    check("load_c2_done", 32'(done), 32'd1);
    check("load_c2_ctrl", 32'(usr_control), 32'd0);
    check("load_usr",     32'(usr_q), 32'hB);

    // 3: SHR len 3, serial in 0
    sr_in = 1'b0;
    issue(2'b01, 4'd3);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("shr_ctrl", 32'(usr_control), 32'h1);
      check("shr_rem",  32'(shift_rem), 32'(4 - k));
      check("shr_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("shr_c4_done", 32'(done), 32'd1);
    check("shr_c4_rem",  32'(shift_rem), 32'd0);
    check("shr_usr",     32'(usr_q), 32'h1);

    // 4: SHL len 0
    issue(2'b10, 4'd0);
    @(negedge clk);
    check("shl0_done",    32'(done), 32'd1);
    check("shl0_ctrl",    32'(usr_control), 32'd0);
    check("shl0_aborted", 32'(aborted), 32'd0);
    check("shl0_usr",     32'(usr_q), 32'h1);

    // 5: SHL len 8, abort sampled at the end of cycle 3
    sl_in = 1'b1;
    issue(2'b10, 4'd8);
    @(negedge clk);
    check("abt_c1_ctrl", 32'(usr_control), 32'h2);
    check("abt_c1_rem",  32'(shift_rem), 32'd8);
    @(posedge clk); #2;
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    check("abt_c4_done",    32'(done), 32'd1);
    check("abt_c4_aborted", 32'(aborted), 32'd1);
    check("abt_c4_ctrl",    32'(usr_control), 32'd0);
    check("abt_c4_rem",     32'(shift_rem), 32'd0);
    check("abt_usr",        32'(usr_q), 32'hF);
    @(negedge clk);
    check("abt_c5_ready", 32'(cmd_ready), 32'd1);
    check("abt_c5_done",  32'(done), 32'd0);

    // 6: reset in cycle 2 of SHR len 5, then a normal LOAD
    issue(2'b01, 4'd5);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_ctrl",  32'(usr_control), 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    check("arst_rem",   32'(shift_rem), 32'd0);
    check("arst_done",  32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_usr", 32'(usr_q), 32'h7);
    p_in = 4'b0110;
    issue(2'b11, 4'd0);
    @(negedge clk);
    check("post_rst_ctrl", 32'(usr_control), 32'h3);
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_usr",  32'(usr_q), 32'h6);

    // Random traffic, including held cmd_valid while busy and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rst       = ($urandom_range(0, 199) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op    = 2'($urandom);
      cmd_len   = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
      abort     = ($urandom_range(0, 7) == 0);
      sr_in     = 1'($urandom);
      sl_in     = 1'($urandom);
      p_in      = 4'($urandom);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
